// File: rtl/nic_csr_arb.sv
// Round-robin arbiter in front of the NIC control/status register file.
// Serialises requester accesses, waits out the read latency, returns ack and read data.
//
// state  | meaning
// IDLE   | sample pending requests, pick next requester from the RR pointer
// ACCESS | address/data on the regfile port; write strobe high for writes
// WAIT   | read only: hold address for the remaining RD_LATENCY-1 cycles
// ACK    | one-cycle ack pulse to the granted requester, advance the RR pointer
module nic_csr_arb #(
  parameter int REQ_CNT    = 2,
  parameter int A_WIDTH    = 10,
  parameter int D_WIDTH    = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [REQ_CNT-1:0]              req_rd_i,
  input  logic [REQ_CNT-1:0]              req_wr_i,
  input  logic [REQ_CNT*A_WIDTH-1:0]      req_addr_i,
  input  logic [REQ_CNT*D_WIDTH-1:0]      req_wr_data_i,
  input  logic [REQ_CNT*(D_WIDTH/8)-1:0]  req_be_i,
  output logic [REQ_CNT-1:0]              req_ack_o,
  output logic [D_WIDTH-1:0]              req_rd_data_o,
  output logic [A_WIDTH-1:0]              csr_addr_o,
  output logic                            csr_wr_en_o,
  output logic [D_WIDTH-1:0]              csr_wr_data_o,
  output logic [D_WIDTH/8-1:0]            csr_be_o,
  input  logic [D_WIDTH-1:0]              csr_rd_data_i
);

  localparam int IDX_W = $clog2(REQ_CNT);
  localparam int BE_W  = D_WIDTH / 8;
  localparam int CNT_W = 2;
  // WAIT covers RD_LATENCY-1 cycles; the down-counter terminates at zero.
  localparam logic [CNT_W-1:0] WAIT_LOAD = (RD_LATENCY > 1) ? CNT_W'(RD_LATENCY - 2) : '0;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(REQ_CNT - 1);
  localparam logic [IDX_W:0]   CNT_EXT   = (IDX_W + 1)'(REQ_CNT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    ACK    = 2'd3
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   grant;
  logic               grant_wr;
  logic [CNT_W-1:0]   wait_cnt;

  logic [REQ_CNT-1:0] pending;
  logic [REQ_CNT-1:0] grant_onehot;
  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  logic [IDX_W:0]     cand_ext;
  logic [IDX_W-1:0]   cand;
  logic [A_WIDTH-1:0] sel_addr;
  logic [D_WIDTH-1:0] sel_wdata;
  logic [BE_W-1:0]    sel_be;

  assign pending      = req_rd_i | req_wr_i;
  assign grant_onehot = REQ_CNT'(1) << grant;

  // First pending requester at or above the RR pointer, wrapping around.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand_ext  = '0;
    cand      = '0;
    for (int k = 0; k < REQ_CNT; k++) begin
      cand_ext = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
      if (cand_ext >= CNT_EXT) cand_ext = cand_ext - CNT_EXT;
      cand = cand_ext[IDX_W-1:0];
      if (!sel_found && pending[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_addr  = req_addr_i[sel_idx*A_WIDTH +: A_WIDTH];
    sel_wdata = req_wr_data_i[sel_idx*D_WIDTH +: D_WIDTH];
    sel_be    = req_be_i[sel_idx*BE_W +: BE_W];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      grant         <= '0;
      grant_wr      <= 1'b0;
      wait_cnt      <= '0;
      req_ack_o     <= '0;
      req_rd_data_o <= '0;
      csr_addr_o    <= '0;
      csr_wr_en_o   <= 1'b0;
      csr_wr_data_o <= '0;
      csr_be_o      <= '0;
    end else begin
      req_ack_o <= '0;
      case (state)
        IDLE: begin
          csr_wr_en_o <= 1'b0;
          if (sel_found) begin
            grant         <= sel_idx;
            grant_wr      <= req_wr_i[sel_idx];
            csr_addr_o    <= sel_addr;
            csr_wr_data_o <= sel_wdata;
            csr_be_o      <= sel_be;
            // rd+wr together from one requester is a write
            csr_wr_en_o   <= req_wr_i[sel_idx];
            state         <= ACCESS;
          end
        end
        ACCESS: begin
          csr_wr_en_o <= 1'b0;
          if (grant_wr) begin
            req_ack_o <= grant_onehot;
            state     <= ACK;
          end else if (RD_LATENCY == 1) begin
            req_rd_data_o <= csr_rd_data_i;
            req_ack_o     <= grant_onehot;
            state         <= ACK;
          end else begin
            wait_cnt <= WAIT_LOAD;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            req_rd_data_o <= csr_rd_data_i;
            req_ack_o     <= grant_onehot;
            state         <= ACK;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ACK: begin
          rr_ptr <= (grant == LAST_IDX) ? '0 : grant + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nic_csr_arb.sv
// Bench for nic_csr_arb: RD_LATENCY=3 instance driven through a scoreboard,
// plus an RD_LATENCY=1 instance for the short read path.
module tb_nic_csr_arb;
  localparam int N  = 2;
  localparam int AW = 10;
  localparam int DW = 16;
  localparam int BW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // RD_LATENCY=3 instance
  logic [N-1:0]    a_rd, a_wr, a_ack;
  logic [N*AW-1:0] a_addr;
  logic [N*DW-1:0] a_wdata;
  logic [N*BW-1:0] a_be;
  logic [DW-1:0]   a_rdata, a_cwdata, a_crdata;
  logic [AW-1:0]   a_caddr, a_a1, a_a2;
  logic            a_wren;
  logic [BW-1:0]   a_cbe;

  // RD_LATENCY=1 instance
  logic [N-1:0]    b_rd, b_wr, b_ack;
  logic [N*AW-1:0] b_addr;
  logic [N*DW-1:0] b_wdata;
  logic [N*BW-1:0] b_be;
  logic [DW-1:0]   b_rdata, b_cwdata, b_crdata;
  logic [AW-1:0]   b_caddr;
  logic            b_wren;
  logic [BW-1:0]   b_cbe;

  nic_csr_arb #(.REQ_CNT(N), .A_WIDTH(AW), .D_WIDTH(DW), .RD_LATENCY(3)) dut_a (
    .clk_i(clk), .rst_i(rst),
    .req_rd_i(a_rd), .req_wr_i(a_wr), .req_addr_i(a_addr),
    .req_wr_data_i(a_wdata), .req_be_i(a_be),
    .req_ack_o(a_ack), .req_rd_data_o(a_rdata),
    .csr_addr_o(a_caddr), .csr_wr_en_o(a_wren), .csr_wr_data_o(a_cwdata),
    .csr_be_o(a_cbe), .csr_rd_data_i(a_crdata)
  );

  nic_csr_arb #(.REQ_CNT(N), .A_WIDTH(AW), .D_WIDTH(DW), .RD_LATENCY(1)) dut_b (
    .clk_i(clk), .rst_i(rst),
    .req_rd_i(b_rd), .req_wr_i(b_wr), .req_addr_i(b_addr),
    .req_wr_data_i(b_wdata), .req_be_i(b_be),
    .req_ack_o(b_ack), .req_rd_data_o(b_rdata),
    .csr_addr_o(b_caddr), .csr_wr_en_o(b_wren), .csr_wr_data_o(b_cwdata),
    .csr_be_o(b_cbe), .csr_rd_data_i(b_crdata)
  );

  // Regfile model: data for an address appears RD_LATENCY cycles after it is presented.
  function automatic logic [DW-1:0] rf_read(input logic [AW-1:0] a);
    if (a == 10'h010) return 16'h1234;
    if (a == 10'h011) return 16'hA5C3;
    return {6'h00, a} ^ 16'h5A00;
  endfunction

  always @(posedge clk) begin
    a_a1 <= a_caddr;
    a_a2 <= a_a1;
  end
  assign a_crdata = rf_read(a_a2);
  assign b_crdata = rf_read(b_caddr);

  typedef struct {
    logic [N-1:0]  ack;
    logic [DW-1:0] rd;
    logic [AW-1:0] addr;
    int            cyc;
  } ack_t;
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BW-1:0] be;
    int            cyc;
  } wr_t;

  ack_t aq[$];
  wr_t  wq[$];
  ack_t e;
  wr_t  w;

  task automatic push_wr(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input logic [BW-1:0] be, input int c);
    wr_t t;
    t.addr = addr; t.data = data; t.be = be; t.cyc = c;
    wq.push_back(t);
  endtask

  task automatic push_ack(input logic [N-1:0] ack, input logic [DW-1:0] rd,
                          input logic [AW-1:0] addr, input int c);
    ack_t t;
    t.ack = ack; t.rd = rd; t.addr = addr; t.cyc = c;
    aq.push_back(t);
  endtask

  // Scoreboard monitor for instance A, sampled mid-cycle.
  always @(negedge clk) begin
    if (a_wren) begin
      checks++;
      assert (wq.size() > 0) else begin
        errors++;
        $error("FAIL wr_strobe_unexpected observed addr=%h cyc=%0d expected no strobe", a_caddr, cyc);
      end
      if (wq.size() > 0) begin
        w = wq.pop_front();
        checks++;
        assert ({a_caddr, a_cwdata, a_cbe, cyc} === {w.addr, w.data, w.be, w.cyc}) else begin
          errors++;
          $error("FAIL wr_strobe observed addr=%h data=%h be=%b cyc=%0d expected addr=%h data=%h be=%b cyc=%0d",
                 a_caddr, a_cwdata, a_cbe, cyc, w.addr, w.data, w.be, w.cyc);
        end
      end
    end
    if (a_ack != '0) begin
      checks++;
      assert ($onehot(a_ack) === 1'b1) else begin
        errors++;
        $error("FAIL ack_onehot observed=%b expected one-hot", a_ack);
      end
      checks++;
      assert (aq.size() > 0) else begin
        errors++;
        $error("FAIL ack_unexpected observed=%b cyc=%0d expected no ack", a_ack, cyc);
      end
      if (aq.size() > 0) begin
        e = aq.pop_front();
        checks++;
        assert ({a_ack, a_rdata, a_caddr, cyc} === {e.ack, e.rd, e.addr, e.cyc}) else begin
          errors++;
          $error("FAIL ack observed ack=%b rd=%h addr=%h cyc=%0d expected ack=%b rd=%h addr=%h cyc=%0d",
                 a_ack, a_rdata, a_caddr, cyc, e.ack, e.rd, e.addr, e.cyc);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int idx, input bit drop);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 40 && !seen; t++) begin
      @(negedge clk);
      if (a_ack[idx]) seen = 1'b1;
    end
    checks++;
    assert (seen === 1'b1) else begin
      errors++;
      $error("FAIL ack_timeout req%0d observed=%0b expected=1", idx, seen);
    end
    if (drop) begin
      a_rd[idx] = 1'b0;
      a_wr[idx] = 1'b0;
    end
  endtask

  int            c0;
  logic [DW-1:0] exp_rd;
  bit            b_seen, b_wr_seen;
  logic [N-1:0]  b_ack_v;
  int            b_cyc;
  logic [DW-1:0] b_data;

  initial begin
    a_rd = '0; a_wr = '0; a_addr = '0; a_wdata = '0; a_be = '0;
    b_rd = '0; b_wr = '0; b_addr = '0; b_wdata = '0; b_be = '0;
    exp_rd = '0;
    rst = 1'b1;
    step(2);
    checks++;
    assert ({a_ack, a_rdata, a_caddr, a_wren, a_cwdata, a_cbe} === 47'd0) else begin
      errors++;
      $error("FAIL reset_a observed ack=%b rd=%h addr=%h wren=%b wd=%h be=%b expected all 0",
             a_ack, a_rdata, a_caddr, a_wren, a_cwdata, a_cbe);
    end
    checks++;
    assert ({b_ack, b_rdata, b_caddr, b_wren, b_cwdata, b_cbe} === 47'd0) else begin
      errors++;
      $error("FAIL reset_b observed ack=%b rd=%h addr=%h wren=%b expected all 0",
             b_ack, b_rdata, b_caddr, b_wren);
    end
    rst = 1'b0;
    step(1);

    // RD_LATENCY=1 read: req 1, addr 0x010
    b_rd[1] = 1'b1;
    b_addr[AW +: AW] = 10'h010;
    c0 = cyc;
    b_seen = 1'b0; b_wr_seen = 1'b0; b_ack_v = '0; b_cyc = -1; b_data = '0;
    for (int t = 0; t < 20 && !b_seen; t++) begin
      @(negedge clk);
      if (b_wren) b_wr_seen = 1'b1;
      if (b_ack != '0) begin
        b_seen = 1'b1; b_ack_v = b_ack; b_cyc = cyc; b_data = b_rdata;
      end
    end
    b_rd[1] = 1'b0;
    checks++;
    assert (b_ack_v === 2'b10) else begin
      errors++; $error("FAIL lat1_ack observed=%b expected=10", b_ack_v);
    end
    checks++;
    assert (b_cyc === c0 + 2) else begin
      errors++; $error("FAIL lat1_ack_cycle observed=%0d expected=%0d", b_cyc, c0 + 2);
    end
    checks++;
    assert (b_data === 16'h1234) else begin
      errors++; $error("FAIL lat1_rd_data observed=%h expected=1234", b_data);
    end
    checks++;
    assert (b_wr_seen === 1'b0) else begin
      errors++; $error("FAIL lat1_wr_en observed=%b expected=0", b_wr_seen);
    end
    step(1);

    // Single write on req 0
    a_wr[0] = 1'b1;
    a_addr[0 +: AW] = 10'h005; a_wdata[0 +: DW] = 16'hBEEF; a_be[0 +: BW] = 2'b11;
    c0 = cyc;
    push_wr(10'h005, 16'hBEEF, 2'b11, c0 + 1);
    push_ack(2'b01, exp_rd, 10'h005, c0 + 2);
    wait_ack(0, 1'b1);
    step(1);

    // Single read on req 1, RD_LATENCY=3
    a_rd[1] = 1'b1;
    a_addr[AW +: AW] = 10'h010;
    c0 = cyc;
    exp_rd = 16'h1234;
    push_ack(2'b10, exp_rd, 10'h010, c0 + 4);
    wait_ack(1, 1'b1);
    step(1);

    // Contention: both writing continuously for 6 accesses
    a_wr = 2'b11;
    a_addr[0 +: AW] = 10'h020; a_wdata[0 +: DW] = 16'h1111; a_be[0 +: BW] = 2'b01;
    a_addr[AW +: AW] = 10'h021; a_wdata[DW +: DW] = 16'h2222; a_be[BW +: BW] = 2'b10;
    c0 = cyc;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) begin
        push_wr(10'h020, 16'h1111, 2'b01, c0 + 1 + 3 * k);
        push_ack(2'b01, exp_rd, 10'h020, c0 + 2 + 3 * k);
      end else begin
        push_wr(10'h021, 16'h2222, 2'b10, c0 + 1 + 3 * k);
        push_ack(2'b10, exp_rd, 10'h021, c0 + 2 + 3 * k);
      end
    end
    for (int k = 0; k < 6; k++) wait_ack(k % 2, 1'b0);
    a_wr = '0;
    step(1);

    // Simultaneous rd+wr on req 0 behaves as a write
    a_rd[0] = 1'b1; a_wr[0] = 1'b1;
    a_addr[0 +: AW] = 10'h030; a_wdata[0 +: DW] = 16'hCAFE; a_be[0 +: BW] = 2'b11;
    c0 = cyc;
    push_wr(10'h030, 16'hCAFE, 2'b11, c0 + 1);
    push_ack(2'b01, exp_rd, 10'h030, c0 + 2);
    wait_ack(0, 1'b1);
    step(1);

    // Reset while req 1 read is in WAIT; RR pointer is 1 at this point
    a_rd[1] = 1'b1;
    a_addr[AW +: AW] = 10'h011;
    step(2);
    rst = 1'b1;
    step(1);
    checks++;
    assert ({a_ack, a_rdata, a_caddr, a_wren, a_cwdata, a_cbe} === 47'd0) else begin
      errors++;
      $error("FAIL reset_in_wait observed ack=%b rd=%h addr=%h wren=%b wd=%h be=%b expected all 0",
             a_ack, a_rdata, a_caddr, a_wren, a_cwdata, a_cbe);
    end
    rst = 1'b0;
    exp_rd = '0;
    a_wr[0] = 1'b1;
    a_addr[0 +: AW] = 10'h032; a_wdata[0 +: DW] = 16'h7777; a_be[0 +: BW] = 2'b01;
    c0 = cyc;
    push_wr(10'h032, 16'h7777, 2'b01, c0 + 1);
    push_ack(2'b01, 16'h0000, 10'h032, c0 + 2);
    push_ack(2'b10, 16'hA5C3, 10'h011, c0 + 7);
    wait_ack(0, 1'b1);
    wait_ack(1, 1'b1);
    exp_rd = 16'hA5C3;
    step(1);

    // Req 1 pulses for one cycle while req 0 is being served
    a_wr[0] = 1'b1;
    a_addr[0 +: AW] = 10'h040; a_wdata[0 +: DW] = 16'h0F0F; a_be[0 +: BW] = 2'b11;
    c0 = cyc;
    push_wr(10'h040, 16'h0F0F, 2'b11, c0 + 1);
    push_ack(2'b01, exp_rd, 10'h040, c0 + 2);
    step(1);
    a_rd[1] = 1'b1;
    a_addr[AW +: AW] = 10'h041;
    step(1);
    a_rd[1] = 1'b0;
    wait_ack(0, 1'b1);

    step(12);
    checks++;
    assert (aq.size() === 0) else begin
      errors++; $error("FAIL ack_queue_drain observed=%0d pending expected=0", aq.size());
    end
    checks++;
    assert (wq.size() === 0) else begin
      errors++; $error("FAIL wr_queue_drain observed=%0d pending expected=0", wq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nic_csr_arb.md
Name: nic_csr_arb

Overview:
- Round-robin arbiter that shares the single NIC control/status regfile port between REQ_CNT register-access requesters, e.g. the host CPU bridge and the boot-time MAC/MTU loader.
- Sits directly in front of the NIC control register file and drives its address, write-enable, write-data and byte-enable inputs.
- Serialises accesses, inserts the regfile read latency and returns per-requester acknowledge and read data.

Parameters:
- REQ_CNT, 2, number of requesters; 2..8.
- A_WIDTH, 10, regfile address width.
- D_WIDTH, 16, regfile data width.
- RD_LATENCY, 1, cycles from address presented to regfile read data valid; 1..4.

Ports:
- clk_i  in  1  single clock; the regfile clock.
- rst_i  in  1  synchronous, active-high reset.
- req_rd_i  in  REQ_CNT  per-requester read request, level, held until ack.
- req_wr_i  in  REQ_CNT  per-requester write request, level, held until ack.
- req_addr_i  in  REQ_CNT*A_WIDTH  packed addresses; requester i at [i*A_WIDTH +: A_WIDTH].
- req_wr_data_i  in  REQ_CNT*D_WIDTH  packed write data.
- req_be_i  in  REQ_CNT*(D_WIDTH/8)  packed byte enables.
- req_ack_o  out  REQ_CNT  one-cycle completion pulse, one-hot.
- req_rd_data_o  out  D_WIDTH  read data, shared, valid when req_ack_o is asserted for a read.
- csr_addr_o  out  A_WIDTH  regfile address.
- csr_wr_en_o  out  1  regfile write strobe.
- csr_wr_data_o  out  D_WIDTH  regfile write data.
- csr_be_o  out  D_WIDTH/8  regfile byte enables.
- csr_rd_data_i  in  D_WIDTH  regfile read data.

Behaviour:
- Clocking and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- All outputs are registered. On reset every output is 0, the FSM goes to IDLE and the RR pointer is 0.
- FSM states: IDLE, ACCESS, WAIT, ACK.
- IDLE:
  - Pending set is req_rd_i | req_wr_i.
  - If the set is non-empty, select the first pending index starting at the RR pointer and searching upward with wrap.
  - Register that requester's addr, wdata and be onto csr_*_o. Set csr_wr_en_o=1 if its wr bit is set. Go to ACCESS.
  - If the set is empty, stay in IDLE; csr_wr_en_o=0 and the other csr_*_o hold their last values.
- Simultaneous rd and wr from one requester: treated as a write only, with a single ack.
- ACCESS (1 cycle):
  - csr_wr_en_o is high for exactly this cycle on a write. It is cleared on leaving ACCESS.
  - Write: go to ACK.
  - Read with RD_LATENCY=1: capture csr_rd_data_i at the end of this cycle and go to ACK.
  - Read with RD_LATENCY>1: go to WAIT.
- WAIT: a counter runs RD_LATENCY-1 further cycles with the address held. On the last of them, capture csr_rd_data_i and go to ACK.
- ACK (1 cycle):
  - req_ack_o[grant]=1. req_rd_data_o holds the captured data; it is unchanged for writes.
  - RR pointer becomes (grant+1) mod REQ_CNT. Go to IDLE.
- Requester rule: drop the request on the clock edge where its ack is high. IDLE never samples during ACK, so a stale re-grant is impossible.
- Latency, with requests sampled in IDLE at cycle N:
  - Write: csr_wr_en_o high in cycle N+1, ack in cycle N+2.
  - Read: address valid N+1..N+RD_LATENCY, ack in cycle N+1+RD_LATENCY.
- Throughput: one access per 3+(RD_LATENCY-1 for reads) cycles.
- Requester inputs are sampled only in IDLE. Changes while granted are ignored until the next grant.
- Fairness: with all requesters continuously pending, grants rotate 0,1,..,REQ_CNT-1,0. No requester waits more than REQ_CNT-1 accesses.
- A request deasserted before grant is dropped silently, with no ack.
- Reset mid-operation (any state): the access is abandoned, no ack is issued, csr_wr_en_o=0 from the next cycle and the pointer returns to 0.
- req_ack_o is never multi-hot. csr_wr_en_o is never asserted for a read.

Test Plan:
- Single write: req 0 wr, addr 0x005, data 0xBEEF, be 2'b11 at cycle N -> csr_wr_en_o=1 only in N+1 with addr 0x005 and data 0xBEEF; req_ack_o=2'b01 in N+2; a single write strobe.
- Single read, RD_LATENCY=1 and 3: req 1 rd addr 0x010, regfile model returns 0x1234 -> req_ack_o=2'b10 at N+2 (RD_LATENCY=1) and N+4 (RD_LATENCY=3); req_rd_data_o=0x1234; csr_wr_en_o stays 0.
- Contention: reqs 0 and 1 pending continuously for 6 accesses after reset -> grant order 0,1,0,1,0,1; no back-to-back grant while the other is pending.
- Simultaneous rd+wr on req 0 -> treated as a write, exactly one ack, read data output unchanged.
- Reset in WAIT (RD_LATENCY=3): assert rst_i one cycle -> no ack emitted, all outputs 0 next cycle, the next access granted to req 0.
- Withdrawn request: req 1 pulses for one cycle while req 0 is being served -> req 1 never acked, no spurious regfile access.
